// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// Imported by div_step and seq_div.
package div_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } div_state_e;

  localparam int DIV_WIDTH_DEFAULT = 4;

  function automatic int div_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit,
// then conditionally subtract the divisor.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_dvs;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  assign w_shift = {i_rem, i_bit};
  assign w_dvs   = {1'b0, i_div};
  assign w_diff  = w_shift - w_dvs;
  assign w_ge    = (w_shift >= w_dvs);

  // A restored remainder is always below the divisor, so its top bit is 0.
  assign o_rem  = WIDTH'(w_ge ? w_diff : w_shift);
  assign o_qbit = w_ge;

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned restoring divider, one quotient bit per clock,
// with a start/ready handshake and registered results.
module seq_div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             ready
);

  localparam int CW = div_cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  div_state_e       r_state;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_r;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_rem;
  logic             w_qbit;
  logic [WIDTH-1:0] w_d_next;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem  (r_r),
    .i_bit  (r_d[WIDTH-1]),
    .i_div  (r_b),
    .o_rem  (w_rem),
    .o_qbit (w_qbit)
  );

  // Quotient bits fill the dividend register from the LSB as it drains.
  assign w_d_next = {r_d[WIDTH-2:0], w_qbit};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_d     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      quot    <= '0;
      rem     <= '0;
      ready   <= 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_d     <= a;
            r_b     <= b;
            r_r     <= '0;
            r_cnt   <= CNT_INIT;
            r_state <= ST_BUSY;
            ready   <= 1'b0;
          end
        end
        ST_BUSY: begin
          r_d   <= w_d_next;
          r_r   <= w_rem;
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            quot    <= w_d_next;
            rem     <= w_rem;
            r_state <= ST_IDLE;
            ready   <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Directed and table-driven checks for seq_div at WIDTH=4.
// Outputs are sampled on the falling edge.
module tb_seq_div;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       start;
  logic [3:0] quot;
  logic [3:0] rem;
  logic       ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
  } vec_t;

  vec_t vecs[8];

  seq_div #(
    .WIDTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .start (start),
    .quot  (quot),
    .rem   (rem),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Waits at falling edges until ready, returning the number of busy samples.
  task automatic wait_ready(output int busy);
    busy = 0;
    while (ready !== 1'b1 && busy < 20) begin
      busy++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [3:0] ia, input logic [3:0] ib,
                        input logic [3:0] eq, input logic [3:0] er,
                        input string nm);
    int busy;
    @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ready(busy);
    check({nm, "_lat"}, busy, 4);
    check({nm, "_q"}, int'(quot), int'(eq));
    check({nm, "_r"}, int'(rem), int'(er));
  endtask

  initial begin
    int busy;
    logic [3:0] mq;
    logic [3:0] mr;

    vecs[0] = '{4'd13, 4'd3, 4'd4,  4'd1};
    vecs[1] = '{4'd2,  4'd7, 4'd0,  4'd2};
    vecs[2] = '{4'd15, 4'd1, 4'd15, 4'd0};
    vecs[3] = '{4'd9,  4'd0, 4'd15, 4'd9};
    vecs[4] = '{4'd15, 4'd15, 4'd1, 4'd0};
    vecs[5] = '{4'd0,  4'd5, 4'd0,  4'd0};
    vecs[6] = '{4'd14, 4'd4, 4'd3,  4'd2};
    vecs[7] = '{4'd11, 4'd6, 4'd1,  4'd5};

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_quot", int'(quot), 0);
    check("rst_rem", int'(rem), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", int'(ready), 1);

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
             $sformatf("vec%0d", i));

    // Inputs and start changing mid-operation must be ignored.
    @(negedge clk);
    a = 4'd12;
    b = 4'd5;
    start = 1'b1;
    @(negedge clk);
    a = 4'd1;
    b = 4'd1;
    @(negedge clk);
    start = 1'b0;
    wait_ready(busy);
    check("ign_lat", busy, 3);
    check("ign_q", int'(quot), 2);
    check("ign_r", int'(rem), 2);
    repeat (2) @(negedge clk);
    check("ign_idle", int'(ready), 1);
    check("ign_hold_q", int'(quot), 2);

    // start held across completion: one idle cycle, then a repeat.
    a = 4'd7;
    b = 4'd2;
    start = 1'b1;
    @(negedge clk);
    wait_ready(busy);
    check("hold_lat", busy, 4);
    check("hold_q", int'(quot), 3);
    check("hold_r", int'(rem), 1);
    @(negedge clk);
    check("hold_reaccept", int'(ready), 0);
    start = 1'b0;
    wait_ready(busy);
    check("hold2_lat", busy, 4);
    check("hold2_q", int'(quot), 3);
    check("hold2_r", int'(rem), 1);

    // Reset in the middle of an operation discards it.
    @(negedge clk);
    a = 4'd14;
    b = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", int'(ready), 1);
    check("mid_rst_q", int'(quot), 0);
    check("mid_rst_r", int'(rem), 0);
    rst_n = 1'b1;
    run_op(4'd6, 4'd4, 4'd1, 4'd2, "post_rst");

    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        if (ib == 0) begin
          mq = 4'hF;
          mr = 4'(ia);
        end else begin
          mq = 4'(ia / ib);
          mr = 4'(ia % ib);
        end
        run_op(4'(ia), 4'(ib), mq, mr, $sformatf("sw_%0d_%0d", ia, ib));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
